// File: rtl/fp_vector_add_issue.sv
// Operand pairing and issue control for a fixed-latency 4-lane FP vector adder.
// Input vectors are paired and issued only when a slot in the result FIFO is
// reserved. Adder results are buffered and leave over a valid/ready stream.
module fp_vector_add_issue #(
    parameter int EXP_BITS    = 5,
    parameter int MANT_BITS   = 6,
    parameter int ADD_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4,
    localparam int W          = EXP_BITS + MANT_BITS + 1,
    localparam int VEC_W      = 4 * W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_vec,
    input  logic             in_last,
    output logic             add_valid,
    output logic [VEC_W-1:0] add_op1,
    output logic [VEC_W-1:0] add_op2,
    input  logic             res_valid,
    input  logic [VEC_W-1:0] res_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_vec,
    output logic             overflow
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;

    generate
        if (FIFO_DEPTH < ADD_LATENCY + 1) begin : g_depth_check
            $error("FIFO_DEPTH must be at least ADD_LATENCY+1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [VEC_W-1:0] op1_hold;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [VEC_W-1:0] mem [FIFO_DEPTH];
    logic             run;
    logic [LW-1:0]    ignore_cnt;

    logic             accept, issue, latch;
    logic [CW:0]      occupied;
    logic             credit_ok;
    logic             res_take, full, pop, wr_en, drop, ret_dec;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop in the same cycle is deliberately not credited, which keeps
    // in_ready independent of out_ready.
    assign occupied  = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok = occupied < (CW+1)'(FIFO_DEPTH);

    // Results that straggle in from before a reset are ignored until the
    // post-reset window closes; stale returns must not refill the FIFO.
    assign res_take = res_valid && (ignore_cnt == '0);
    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign pop      = out_valid && out_ready;
    assign wr_en    = res_take && (!full || pop);
    assign drop     = res_take && full && !pop;
    assign ret_dec  = res_take && (inflight != '0);

    assign out_valid = (fifo_count != '0);
    assign out_vec   = mem[rd_ptr];

    // Pairing FSM next state and input handshake decode.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        issue      = 1'b0;
        latch      = 1'b0;
        if (run) begin
            // Latching the first operand consumes no result slot.
            in_ready = (state == IDLE && !in_last) ? 1'b1 : credit_ok;
        end
        accept = in_valid && in_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        issue = 1'b1;
                    end else begin
                        latch      = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    issue      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset release tracking: enables input after the first edge and opens
    // the result path once ADD_LATENCY cycles have passed.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            run        <= 1'b0;
            ignore_cnt <= LW'(ADD_LATENCY);
        end else begin
            run <= 1'b1;
            if (ignore_cnt != '0) begin
                ignore_cnt <= ignore_cnt - LW'(1);
            end
        end
    end

    // FSM state, held operand and the registered issue port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op1_hold  <= '0;
            add_valid <= 1'b0;
            add_op1   <= '0;
            add_op2   <= '0;
        end else begin
            state     <= state_next;
            add_valid <= issue;
            if (latch) begin
                op1_hold <= in_vec;
            end
            if (issue) begin
                // An odd final vector is paired with an all-zero (+0) operand.
                add_op1 <= (state == HOLD) ? op1_hold : in_vec;
                add_op2 <= (state == HOLD) ? in_vec : '0;
            end
        end
    end

    // Credit counters, FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            inflight   <= inflight + CW'(issue) - CW'(ret_dec);
            fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
            if (wr_en) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Result storage, written in place at the tail pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; fifo_count alone says which
        // entries are meaningful, so clearing the data would buy nothing.
        if (wr_en) begin
            mem[wr_ptr] <= res_vec;
        end
    end

endmodule
